qpp_deinterleaver: RTL and testbench
====================================

# qpp_deinterleaver

Streaming QPP (LTE turbo) deinterleaver for block sizes K = 6144 and K = 1056. It accepts interleaved bits c'[j] = c[π(j)] serially, one bit per cycle, and scatters each bit into a K-bit buffer at address π(j). It then drains the restored block c[0..K-1] in natural order. It sits on the receive side of the coder path and undoes the QPP permutation π(j) = (f1·j + f2·j²) mod K applied by the coder interleaver.

## Interface
- F1_6144, 263, QPP f1 for K = 6144
- F2_6144, 480, QPP f2 for K = 6144
- F1_1056, 17, QPP f1 for K = 1056
- F2_1056, 66, QPP f2 for K = 1056
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- K_eq_6144  in  1  block-size select: 1 → K = 6144, 0 → K = 1056; sampled only when bit j = 0 is accepted
- in_valid  in  1  in_bit holds an interleaved bit
- in_bit  in  1  interleaved bit c'[j]
- in_ready  out  1  block can accept an input bit (high only in LOAD)
- out_valid  out  1  out_bit holds a deinterleaved bit (high only in DRAIN)
- out_bit  out  1  deinterleaved bit c[i]
- out_ready  in  1  downstream accepts out_bit
- out_last  out  1  out_valid and i = K-1
- busy  out  1  a block is in progress (LOAD with j > 0, or DRAIN)

## Operation
- States: LOAD and DRAIN. Reset enters LOAD with j = 0, i = 0, pi = 0, g = 0, k_sel = 0.
- Input accept occurs when in_valid & in_ready. On accept:
  - buf[pi] ← in_bit.
  - If j = 0: k_sel ← K_eq_6144, and {f1,f2,K} are selected from the K_eq_6144 input for this cycle only.
- Address recurrence, with every quantity a 13-bit unsigned value mod K:
  - π(0) = 0.
  - g(0) = (f1+f2) mod K.
  - π(j+1) = (π(j) + g(j)) mod K.
  - g(j+1) = (g(j) + 2·f2) mod K.
  - Each sum is < 2K, so each reduction is a single conditional subtract of K. No multipliers.
  - Values: K = 6144 gives g(0) = 743, step 960. K = 1056 gives g(0) = 83, step 132.
- On the accept of j = K-1, the state moves to DRAIN on the next edge, and i is cleared to 0.
- In DRAIN:
  - out_valid = 1 and out_bit = buf[i], driven combinationally from the buffer.
  - On out_valid & out_ready: i ← i+1.
  - On the transfer with i = K-1: return to LOAD with j = 0 and pi = 0.
- k_sel holds K for the whole block. Changes on K_eq_6144 after j = 0 are ignored until the next block.
- The buffer is 6144 flops. Only addresses < K are written or read. It is not cleared by reset; its contents are don't-care until written.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_bit = 0 (gated by out_valid), out_last = 0, busy = 0.
- Throughput is one bit per cycle in each phase.
- Input and output phases do not overlap: in_ready = 0 for the whole of DRAIN, so no input is accepted during it.
- Latency: out_valid rises on the first edge after the accept of j = K-1. Output i = 0 can transfer in that cycle.
- Full block with no stalls: K accept cycles, then K drain cycles. The next block's j = 0 can be accepted on the cycle after the out_last transfer.
- in_valid low or out_ready low stalls the counters and recurrence with no state change.
- Reset asserted mid-LOAD or mid-DRAIN aborts the block immediately: state returns to LOAD, all counters are zeroed, and the partial block is discarded.

## Test plan
- K = 1056 one-hot: send a block with only c'[1] = 1 → exactly one output bit is 1, at i = 83. Repeat with only c'[2] = 1 → output bit 1 at i = 298.
- K = 6144 one-hot: only c'[1] = 1 → output 1 at i = 743. Only c'[2] = 1 → output 1 at i = 2446. out_last coincides with i = 6143.
- Round trip: a random c is interleaved by the behavioural model π(j) = (f1·j + f2·j²) mod K and fed in, for both K → output equals c bit-exactly. After the last output, in_ready = 1 and busy = 0.
- Backpressure: random in_valid gaps and random out_ready low → output identical to the no-stall run. in_ready = 0 throughout DRAIN. No extra or dropped bits.
- K latch: set K_eq_6144 = 0 at j = 0, then toggle it to 1 during LOAD → exactly 1056 inputs are accepted and 1056 outputs are produced.
- Reset mid-block: assert rst at j = 500 of a 6144 block → next cycle in_ready = 1, out_valid = 0, busy = 0. A fresh K = 1056 block then deinterleaves correctly.

Source files
------------

// File: rtl/qpp_deinterleaver.sv
// Streaming QPP (LTE turbo) deinterleaver for K = 6144 and K = 1056.
// Interleaved bits are scattered into a K-bit buffer at address pi(j), with
// pi(j) generated by a two-register add/subtract recurrence. The restored
// block is then drained in natural order.
module qpp_deinterleaver #(
    parameter int F1_6144 = 263,
    parameter int F2_6144 = 480,
    parameter int F1_1056 = 17,
    parameter int F2_1056 = 66
) (
    input  logic clk,
    input  logic rst,
    input  logic K_eq_6144,
    input  logic in_valid,
    input  logic in_bit,
    output logic in_ready,
    output logic out_valid,
    output logic out_bit,
    input  logic out_ready,
    output logic out_last,
    output logic busy
);

    localparam int KMAX = 6144;
    localparam int AW   = 13;

    // Recurrence seeds, folded to constants at elaboration time.
    localparam logic [AW-1:0] K_6144    = AW'(6144);
    localparam logic [AW-1:0] K_1056    = AW'(1056);
    localparam logic [AW-1:0] G0_6144   = AW'((F1_6144 + F2_6144) % 6144);
    localparam logic [AW-1:0] G0_1056   = AW'((F1_1056 + F2_1056) % 1056);
    localparam logic [AW-1:0] STEP_6144 = AW'((2 * F2_6144) % 6144);
    localparam logic [AW-1:0] STEP_1056 = AW'((2 * F2_1056) % 1056);

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state_q;
    logic [AW-1:0] j_q, i_q, pi_q, g_q;
    logic          k_sel_q;
    logic [KMAX-1:0] buf_q;

    logic          in_fire, out_fire;
    logic          k_cur;
    logic [AW-1:0] k_val, k_last, g0, step, g_cur, pi_d, g_d;

    // (a + b) mod m for a, b < m: the sum needs one extra bit before the
    // single conditional subtract brings it back into range.
    function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                              input logic [AW-1:0] b,
                                              input logic [AW-1:0] m);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[AW-1:0];
    endfunction

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_bit   = out_valid & buf_q[i_q];
    assign out_last  = out_valid & (i_q == k_last);
    assign busy      = (state_q == DRAIN) | (j_q != '0);

    // Block-size selection and next address: the first bit of a block takes K
    // straight from the input, later bits use the latched selection.
    always_comb begin
        k_cur  = ((state_q == LOAD) && (j_q == '0)) ? K_eq_6144 : k_sel_q;
        k_val  = k_cur ? K_6144    : K_1056;
        g0     = k_cur ? G0_6144   : G0_1056;
        step   = k_cur ? STEP_6144 : STEP_1056;
        k_last = k_val - AW'(1);
        g_cur  = (j_q == '0) ? g0 : g_q;
        pi_d   = mod_add(pi_q, g_cur, k_val);
        g_d    = mod_add(g_cur, step, k_val);
    end

    // LOAD/DRAIN sequencing, input/output counters and the address recurrence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            j_q     <= '0;
            i_q     <= '0;
            pi_q    <= '0;
            g_q     <= '0;
            k_sel_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_fire) begin
                        if (j_q == '0) k_sel_q <= K_eq_6144;
                        if (j_q == k_last) begin
                            state_q <= DRAIN;
                            j_q     <= '0;
                            pi_q    <= '0;
                            g_q     <= '0;
                            i_q     <= '0;
                        end else begin
                            j_q  <= j_q + AW'(1);
                            pi_q <= pi_d;
                            g_q  <= g_d;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (i_q == k_last) begin
                            state_q <= LOAD;
                            i_q     <= '0;
                        end else begin
                            i_q <= i_q + AW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Scatter each accepted bit to its deinterleaved position.
    // NOTE: the buffer has no reset; every location read in DRAIN was written
    // earlier in the same block, so clearing it would only cost a reset fanout.
    always_ff @(posedge clk) begin
        if (in_fire) buf_q[pi_q] <= in_bit;
    end

endmodule

// File: tb/tb_qpp_deinterleaver.sv
// Scoreboard bench for qpp_deinterleaver: drivers push the expected restored
// block into a queue, and a monitor pops and compares on every output transfer.
module tb_qpp_deinterleaver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic K_eq_6144 = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, out_bit, out_last, busy;

    always #5 clk = ~clk;

    qpp_deinterleaver dut (
        .clk       (clk),
        .rst       (rst),
        .K_eq_6144 (K_eq_6144),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    typedef struct packed {
        logic        b;
        logic        last;
        logic [12:0] idx;
    } expect_t;

    expect_t sb[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    bit      bp_en    = 1'b0;
    bit      c_bits   [6144];
    bit      cp_bits  [6144];
    bit      c_save   [6144];
    bit      cp_save  [6144];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Direct QPP formula, independent of the hardware recurrence.
    function automatic int pi_model(input int k, input int j);
        longint f1, f2;
        f1 = (k == 6144) ? 263 : 17;
        f2 = (k == 6144) ? 480 : 66;
        return int'((f1 * j + f2 * longint'(j) * j) % k);
    endfunction

    task automatic clear_block();
        for (int i = 0; i < 6144; i++) begin
            c_bits[i]  = 1'b0;
            cp_bits[i] = 1'b0;
        end
    endtask

    task automatic build_onehot(input int jpos, input int ipos);
        clear_block();
        cp_bits[jpos] = 1'b1;
        c_bits[ipos]  = 1'b1;
    endtask

    task automatic build_random(input int k);
        clear_block();
        for (int i = 0; i < k; i++) c_bits[i] = 1'($urandom_range(0, 1));
        for (int j = 0; j < k; j++) cp_bits[j] = c_bits[pi_model(k, j)];
    endtask

    task automatic push_expected(input int k);
        expect_t e;
        for (int i = 0; i < k; i++) begin
            e.b    = c_bits[i];
            e.last = (i == k - 1);
            e.idx  = 13'(i);
            sb.push_back(e);
        end
    endtask

    // Feed cp_bits[0..n-1]; optional random in_valid gaps and K toggling after j = 0.
    task automatic send(input bit k6144, input int n, input bit gaps, input bit toggle);
        int j   = 0;
        int cyc = 0;
        while (j < n) begin
            @(posedge clk);
            #1;
            in_valid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_bit    = cp_bits[j];
            K_eq_6144 = (toggle && j != 0) ? !k6144 : k6144;
            @(negedge clk);
            if (in_valid && in_ready) j++;
            cyc++;
            if (cyc > 4 * n + 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: accepted %0d, expected %0d", j, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the scoreboard to empty, then confirm the block has closed.
    task automatic wait_drain(input string name);
        int cyc = 0;
        while (sb.size() != 0 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain_timeout: %0d outputs still pending, expected 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
        check({name, "_in_ready_after"}, in_ready, 1);
        check({name, "_busy_after"}, busy, 0);
        check({name, "_out_valid_after"}, out_valid, 0);
    endtask

    // Output ready: always high, or randomly low when backpressure is enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: a transfer happens on the next edge when out_valid & out_ready.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                check("in_ready_during_drain", in_ready, 0);
                if (out_ready) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output: got bit %0b with empty scoreboard, expected none", out_bit);
                    end else begin
                        e = sb.pop_front();
                        if (out_bit !== e.b || out_last !== e.last) begin
                            n_fail++;
                            $display("FAIL out[%0d]: got bit=%0b last=%0b, expected bit=%0b last=%0b",
                                     e.idx, out_bit, out_last, e.b, e.last);
                        end
                    end
                end
            end
        end
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bit", out_bit, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // K = 1056 one-hot: c'[1] lands at 83, c'[2] at 298.
        build_onehot(1, 83);
        push_expected(1056);
        send(1'b0, 1056, 1'b0, 1'b0);
        wait_drain("oh1056_j1");

        build_onehot(2, 298);
        push_expected(1056);
        send(1'b0, 1056, 1'b0, 1'b0);
        wait_drain("oh1056_j2");

        // K = 6144 one-hot: c'[1] lands at 743, c'[2] at 2446.
        build_onehot(1, 743);
        push_expected(6144);
        send(1'b1, 6144, 1'b0, 1'b0);
        wait_drain("oh6144_j1");

        build_onehot(2, 2446);
        push_expected(6144);
        send(1'b1, 6144, 1'b0, 1'b0);
        wait_drain("oh6144_j2");

        // Round trip with random data for both block sizes.
        build_random(6144);
        push_expected(6144);
        send(1'b1, 6144, 1'b0, 1'b0);
        wait_drain("rt6144");

        build_random(1056);
        for (int i = 0; i < 6144; i++) begin
            c_save[i]  = c_bits[i];
            cp_save[i] = cp_bits[i];
        end
        push_expected(1056);
        send(1'b0, 1056, 1'b0, 1'b0);
        wait_drain("rt1056");

        // Same K = 1056 block with input gaps and output backpressure.
        for (int i = 0; i < 6144; i++) begin
            c_bits[i]  = c_save[i];
            cp_bits[i] = cp_save[i];
        end
        bp_en = 1'b1;
        push_expected(1056);
        send(1'b0, 1056, 1'b1, 1'b0);
        wait_drain("bp1056");
        bp_en = 1'b0;

        // K latch: K_eq_6144 toggles high after j = 0, block stays at 1056.
        build_random(1056);
        push_expected(1056);
        send(1'b0, 1056, 1'b0, 1'b1);
        @(negedge clk);
        check("klatch_in_ready_after_1056", in_ready, 0);
        wait_drain("klatch");

        // Reset at j = 500 of a K = 6144 block.
        build_random(6144);
        send(1'b1, 500, 1'b0, 1'b0);
        @(negedge clk);
        check("mid_busy_before_rst", busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        build_random(1056);
        push_expected(1056);
        send(1'b0, 1056, 1'b0, 1'b0);
        wait_drain("post_rst1056");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
